// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
// Holds command encodings, FSM state enum and frame-width multiplier.
package spi_arb_pkg;

    localparam int CMD_W      = 2;
    localparam int FRAME_MULT = 2;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        SEND1,
        WAIT1,
        SEND2,
        WAIT2,
        RESP
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the requester not granted last.
// The pointer resets so that requester 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] grant
);

    logic last;

    always_comb begin
        grant = req;
        if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (take) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Arbitrates two requesters onto one SPI master as addr+data frame pairs.
// Define SPI_ARB_TIMEOUT_EN to enable the per-wait-state watchdog.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter  int N              = 2,
    parameter  int ADDR_SIZE      = 8,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int SW             = (N > 1) ? $clog2(N) : 1,
    localparam int FW             = FRAME_MULT * ADDR_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_write,
    input  logic [2*SW-1:0]        req_slave,
    input  logic [2*ADDR_SIZE-1:0] req_addr,
    input  logic [2*ADDR_SIZE-1:0] req_wdata,
    output logic [1:0]             rsp_valid,
    output logic [ADDR_SIZE-1:0]   rsp_rdata,
    output logic                   rsp_err,
    output logic                   spi_start_tx,
    output logic                   spi_start_rx,
    output logic [SW-1:0]          which_slave_enabled,
    output logic [FW-1:0]          spi_din,
    input  logic                   spi_done,
    input  logic [ADDR_SIZE-1:0]   spi_rx_data
);

    state_e                 state;
    logic [1:0]             grant;
    logic [1:0]             owner;
    logic                   take;
    logic                   wr_q;
    logic [ADDR_SIZE-1:0]   wdata_q;
    logic                   sel_wr;
    logic [SW-1:0]          sel_slave;
    logic [ADDR_SIZE-1:0]   sel_addr;
    logic [ADDR_SIZE-1:0]   sel_wdata;

    function automatic logic [FW-1:0] frame(
        input cmd_e                 cmd,
        input logic [ADDR_SIZE-1:0] b
    );
        logic [FW-1:0] f;
        f = '0;
        f[FW-1 -: CMD_W] = cmd;
        f[ADDR_SIZE-1:0] = b;
        return f;
    endfunction

    assign take      = (state == IDLE) && (|req_valid) && !rst;
    assign req_ready = take ? grant : 2'b00;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .take  (take),
        .grant (grant)
    );

    always_comb begin
        sel_wr    = grant[1] ? req_write[1] : req_write[0];
        sel_slave = grant[1] ? req_slave[2*SW-1:SW] : req_slave[SW-1:0];
        sel_addr  = grant[1] ? req_addr[2*ADDR_SIZE-1:ADDR_SIZE]
                             : req_addr[ADDR_SIZE-1:0];
        sel_wdata = grant[1] ? req_wdata[2*ADDR_SIZE-1:ADDR_SIZE]
                             : req_wdata[ADDR_SIZE-1:0];
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt;
    logic          err_q;
    logic          expired;
    assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            owner               <= 2'b00;
            wr_q                <= 1'b0;
            wdata_q             <= '0;
            rsp_valid           <= 2'b00;
            rsp_rdata           <= '0;
            spi_start_tx        <= 1'b0;
            spi_start_rx        <= 1'b0;
            which_slave_enabled <= '0;
            spi_din             <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt                 <= '0;
            err_q               <= 1'b0;
`endif
        end else begin
            spi_start_tx <= 1'b0;
            spi_start_rx <= 1'b0;
            rsp_valid    <= 2'b00;
            unique case (state)
                IDLE: begin
                    if (take) begin
                        owner               <= grant;
                        wr_q                <= sel_wr;
                        wdata_q             <= sel_wdata;
                        which_slave_enabled <= sel_slave;
                        spi_din             <= frame(sel_wr ? CMD_WR_ADDR
                                                            : CMD_RD_ADDR,
                                                     sel_addr);
                        spi_start_tx        <= 1'b1;
                        state               <= SEND1;
                    end
                end
                SEND1: begin
                    state <= WAIT1;
`ifdef SPI_ARB_TIMEOUT_EN
                    cnt   <= '0;
`endif
                end
                WAIT1: begin
                    if (spi_done) begin
                        spi_din      <= wr_q ? frame(CMD_WR_DATA, wdata_q)
                                             : frame(CMD_RD_DATA, '0);
                        spi_start_tx <= wr_q;
                        spi_start_rx <= !wr_q;
                        state        <= SEND2;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (expired) begin
                        rsp_valid <= owner;
                        rsp_rdata <= '0;
                        err_q     <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                SEND2: begin
                    state <= WAIT2;
`ifdef SPI_ARB_TIMEOUT_EN
                    cnt   <= '0;
`endif
                end
                WAIT2: begin
                    if (spi_done) begin
                        rsp_valid <= owner;
                        rsp_rdata <= wr_q ? '0 : spi_rx_data;
                        state     <= RESP;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (expired) begin
                        rsp_valid <= owner;
                        rsp_rdata <= '0;
                        err_q     <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    rsp_rdata <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
                    err_q     <= 1'b0;
`endif
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter: directed table, corner sequences
// and randomized transactions against a transaction-level reference model.
module tb_spi_txn_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_write = '0;
    logic [1:0]  req_slave = '0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        spi_start_tx;
    logic        spi_start_rx;
    logic [0:0]  which_slave_enabled;
    logic [15:0] spi_din;
    logic        spi_done = 1'b0;
    logic [7:0]  spi_rx_data = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int last_m   = 1;

    always #5 clk = ~clk;

    spi_txn_arbiter #(
        .N              (2),
        .ADDR_SIZE      (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_write           (req_write),
        .req_slave           (req_slave),
        .req_addr            (req_addr),
        .req_wdata           (req_wdata),
        .rsp_valid           (rsp_valid),
        .rsp_rdata           (rsp_rdata),
        .rsp_err             (rsp_err),
        .spi_start_tx        (spi_start_tx),
        .spi_start_rx        (spi_start_rx),
        .which_slave_enabled (which_slave_enabled),
        .spi_din             (spi_din),
        .spi_done            (spi_done),
        .spi_rx_data         (spi_rx_data)
    );

    typedef struct {
        logic        rst_first;
        logic [1:0]  v;
        logic [1:0]  wr;
        logic [1:0]  sl;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [7:0]  rx;
        int          d1;
        int          d2;
        logic [1:0]  e_ready;
        logic [15:0] e_f0;
        logic [15:0] e_f1;
        logic        e_rx1;
        logic        e_sl;
        logic [7:0]  e_rdata;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {req_ready, rsp_valid, rsp_rdata, rsp_err, spi_start_tx,
                spi_start_rx, which_slave_enabled, spi_din};
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        spi_done  = 1'b0;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        last_m    = 1;
    endtask

    task automatic do_txn(input string tag, input vec_t t);
        int          t_acc, t_rsp, done_at, nf;
        logic [15:0] fr0, fr1;
        logic        rx1, slv, er;
        logic [1:0]  g, rv;
        logic [7:0]  rd;
        if (t.rst_first) do_reset();
        req_write   = t.wr;
        req_slave   = t.sl;
        req_addr    = t.addr;
        req_wdata   = t.wdata;
        spi_rx_data = t.rx;
        req_valid   = t.v;
        t_acc = -1; t_rsp = -1; done_at = -1; nf = 0;
        fr0 = '0; fr1 = '0; rx1 = 0; slv = 0; er = 0; g = '0; rv = '0;
        rd = '0;
        for (int c = 0; c < 80 && t_rsp < 0; c++) begin
            #1;
            if (t_acc < 0 && req_ready != 2'b00) begin
                t_acc = c;
                g     = req_ready;
            end else if (t_acc >= 0 && c == t_acc + 1) begin
                req_valid = 2'b00;
            end
            if (spi_start_tx || spi_start_rx) begin
                if (nf == 0) begin
                    fr0     = spi_din;
                    done_at = c + t.d1;
                end else if (nf == 1) begin
                    fr1     = spi_din;
                    rx1     = spi_start_rx;
                    done_at = c + t.d2;
                end
                slv = which_slave_enabled;
                nf++;
            end
            if (rsp_valid != 2'b00) begin
                t_rsp = c;
                rv    = rsp_valid;
                rd    = rsp_rdata;
                er    = rsp_err;
            end
            spi_done = (c == done_at);
            @(negedge clk);
        end
        spi_done  = 1'b0;
        req_valid = 2'b00;
        check({tag, "_grant"}, g, t.e_ready);
        check({tag, "_rsp_seen"}, t_rsp >= 0, 1);
        check({tag, "_frame0"}, fr0, t.e_f0);
        check({tag, "_frame1"}, fr1, t.e_f1);
        check({tag, "_nstarts"}, nf, 2);
        check({tag, "_start_rx"}, rx1, t.e_rx1);
        check({tag, "_slave"}, slv, t.e_sl);
        check({tag, "_rsp_valid"}, rv, t.e_ready);
        check({tag, "_rdata"}, rd, t.e_rdata);
        check({tag, "_err"}, er, 0);
        check({tag, "_latency"}, t_rsp - t_acc, 3 + t.d1 + t.d2);
    endtask

    function automatic vec_t model(input vec_t t);
        vec_t e;
        int   w;
        logic [7:0] a, d;
        e = t;
        if (t.v == 2'b11) w = 1 - last_m;
        else              w = (t.v == 2'b10) ? 1 : 0;
        last_m = w;
        a = (w == 1) ? t.addr[15:8] : t.addr[7:0];
        d = (w == 1) ? t.wdata[15:8] : t.wdata[7:0];
        e.e_ready = 2'(1 << w);
        e.e_sl    = t.sl[w];
        if (t.wr[w]) begin
            e.e_f0    = 16'(a);
            e.e_f1    = 16'((1 << 14) + d);
            e.e_rx1   = 1'b0;
            e.e_rdata = 8'h00;
        end else begin
            e.e_f0    = 16'((2 << 14) + a);
            e.e_f1    = 16'(3 << 14);
            e.e_rx1   = 1'b1;
            e.e_rdata = t.rx;
        end
        return e;
    endfunction

    initial begin
        int   ns, dn, bad, s, r;
        logic er;
        logic [1:0] rv;
        logic [7:0] rd;
        vec_t rv_t;

        tbl[0] = '{1'b0, 2'b01, 2'b01, 2'b00, 16'h0012, 16'h00AB, 8'h77,
                   3, 3, 2'b01, 16'h0012, 16'h40AB, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 2'b10, 2'b00, 2'b10, 16'h3400, 16'h0000, 8'h5C,
                   1, 1, 2'b10, 16'h8034, 16'hC000, 1'b1, 1'b1, 8'h5C};
        tbl[2] = '{1'b1, 2'b11, 2'b01, 2'b10, 16'hB1A0, 16'hD1D0, 8'h3C,
                   2, 1, 2'b01, 16'h00A0, 16'h40D0, 1'b0, 1'b0, 8'h00};
        tbl[3] = '{1'b0, 2'b11, 2'b01, 2'b10, 16'hB1A0, 16'hD1D0, 8'h3C,
                   2, 1, 2'b10, 16'h80B1, 16'hC000, 1'b1, 1'b1, 8'h3C};
        tbl[4] = tbl[2];
        tbl[4].rst_first = 1'b0;
        tbl[5] = tbl[3];

        do_reset();
        #1;
        check("reset_outputs_zero", outs(), 0);

        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stray_done_idle_%0d", i), outs(), 0);
            @(negedge clk);
        end

        for (int i = 0; i < 6; i++) do_txn($sformatf("vec%0d", i), tbl[i]);

        do_reset();
        req_write = 2'b00;
        req_slave = 2'b00;
        req_addr  = 16'h0021;
        req_valid = 2'b01;
        ns = 0;
        dn = -1;
        for (int c = 0; c < 30 && ns < 2; c++) begin
            #1;
            if (c == 1) req_valid = 2'b00;
            if (spi_start_tx || spi_start_rx) begin
                ns++;
                dn = c + 1;
            end
            spi_done = (c == dn) && (ns < 2);
            @(negedge clk);
        end
        spi_done = 1'b0;
        check("reach_wait2", ns, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_m = 1;
        #1;
        check("rst_wait2_outputs_zero", outs(), 0);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid != 2'b00) bad = 1;
            @(negedge clk);
            #1;
        end
        check("rst_wait2_no_rsp", bad, 0);

        do_reset();
        for (int i = 0; i < 30; i++) begin
            rv_t.rst_first = 1'b0;
            rv_t.v     = 2'($urandom_range(1, 3));
            rv_t.wr    = 2'($urandom_range(0, 3));
            rv_t.sl    = 2'($urandom_range(0, 3));
            rv_t.addr  = 16'($urandom);
            rv_t.wdata = 16'($urandom);
            rv_t.rx    = 8'($urandom);
            rv_t.d1    = $urandom_range(1, 4);
            rv_t.d2    = $urandom_range(1, 4);
            rv_t = model(rv_t);
            do_txn($sformatf("rnd%0d", i), rv_t);
        end

`ifdef SPI_ARB_TIMEOUT_EN
        do_reset();
        req_write = 2'b00;
        req_addr  = 16'h0055;
        req_valid = 2'b01;
        s = -1; r = -1; er = 0; rd = '1; rv = '0;
        for (int c = 0; c < 60 && r < 0; c++) begin
            #1;
            if (c == 1) req_valid = 2'b00;
            if (spi_start_tx && s < 0) s = c;
            if (rsp_valid != 2'b00) begin
                r  = c;
                er = rsp_err;
                rd = rsp_rdata;
                rv = rsp_valid;
            end
            @(negedge clk);
        end
        check("timeout_rsp_seen", r >= 0, 1);
        check("timeout_latency", r - (s + 1), 16);
        check("timeout_rsp_valid", rv, 2'b01);
        check("timeout_err", er, 1);
        check("timeout_rdata", rd, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
